// File: rtl/netlist_store_ml.sv
// Multi-lane netlist store: header parse, banked gate memory, LANES-wide replay per request.
// Optional build macro NETLIST_XOR_CHECK_EN adds a body XOR-count check against the header.
`timescale 1ns/1ps

module netlist_store_lane #(
    parameter int S    = 14,
    parameter int ROWS = 4096,
    parameter int AW   = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          in_range,
    input  logic          clr,
    input  logic [S-1:0]  lim,
    output logic          gate_valid,
    output logic          is_output,
    output logic [3:0]    g_logic,
    output logic [S-1:0]  in0,
    output logic [S-1:0]  in1,
    output logic          in0F,
    output logic          in1F
);
    logic [31:0] mem [ROWS];
    logic [31:0] word;
    logic        vld;

    // Plain RAM: no reset so the bank maps onto block memory; vld masks the stale word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) word <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst || clr) vld <= 1'b0;
        else if (re)    vld <= in_range;
    end

    assign gate_valid = vld;
    assign is_output  = vld & word[0];
    assign g_logic    = vld ? word[4:1] : 4'd0;
    assign in1        = vld ? word[S+4:5] : '1;
    assign in0        = vld ? S'({1'b0, word[31:S+5]}) : '1;
    assign in0F       = $signed(in0) < $signed(lim);
    assign in1F       = $signed(in1) < $signed(lim);
endmodule

module netlist_store_ml #(
    parameter int S     = 14,
    parameter int LANES = 2,
    parameter int DEPTH = 8192
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 load_valid,
    input  logic [31:0]          load_data,
    output logic                 load_ready,
    input  logic                 run_start,
    input  logic                 rd_req,
    output logic [LANES-1:0]     gate_valid,
    output logic [LANES-1:0]     is_output,
    output logic [4*LANES-1:0]   g_logic,
    output logic [S*LANES-1:0]   in0,
    output logic [S*LANES-1:0]   in1,
    output logic [LANES-1:0]     in0F,
    output logic [LANES-1:0]     in1F,
    output logic [S-1:0]         init_size,
    output logic [S-1:0]         input_size,
    output logic [S-1:0]         dff_size,
    output logic [S-1:0]         gate_size,
    output logic [S-1:0]         output_size,
    output logic [S-1:0]         num_xor,
    output logic                 last,
    output logic                 state_ready,
    output logic                 err
);
    localparam int ROWS = DEPTH / LANES;
    localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LB   = $clog2(LANES);

    typedef enum logic [2:0] {IDLE, HDR, BODY, READY, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [1:0]    hdr_cnt;
    logic [S:0]    tot, wr_idx, grp, hdr_total;
    logic          xfer, ld_go, run_go, rd_go;
    logic          hdr_last, overflow, body_last, grp_last, xor_bad;
    logic [S-1:0]  lim;
    logic [AW-1:0] wr_row;

    assign load_ready  = (state == HDR) || (state == BODY);
    assign state_ready = (state == READY);
    assign xfer        = load_valid && load_ready;
    assign ld_go       = load_start && (state == IDLE || state == READY || state == DONE);
    assign run_go      = run_start && !ld_go && (state == READY || state == RUN || state == DONE);
    assign rd_go       = rd_req && !run_go && (state == RUN);

    // dff_size is already registered when w3 arrives, so total can be formed on the fly.
    assign hdr_last  = xfer && (state == HDR) && (hdr_cnt == 2'd3);
    assign hdr_total = {1'b0, dff_size} + {1'b0, load_data[S-1:0]};
    assign overflow  = 32'(hdr_total) > DEPTH;
    assign body_last = xfer && (state == BODY) && (wr_idx == tot - 1'b1);
    assign grp_last  = ((32'(grp) + 32'd1) * LANES) >= 32'(tot);
    assign wr_row    = AW'(wr_idx >> LB);
    assign lim       = init_size + input_size;

`ifdef NETLIST_XOR_CHECK_EN
    logic [S-1:0] xor_cnt, xor_nx;

    assign xor_nx  = xor_cnt + S'(xfer && (state == BODY) && (load_data[4:1] == 4'b0110));
    assign xor_bad = (hdr_last && !overflow && (hdr_total == '0) && (xor_cnt != load_data[2*S-1:S]))
                   || (body_last && (xor_nx != num_xor));

    always_ff @(posedge clk) begin
        if (rst || ld_go) xor_cnt <= '0;
        else              xor_cnt <= xor_nx;
    end
`else
    assign xor_bad = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ld_go) state_nx = HDR;
            HDR:     if (hdr_last) begin
                         if (overflow)             state_nx = IDLE;
                         else if (hdr_total == '0) state_nx = READY;
                         else                      state_nx = BODY;
                     end
            BODY:    if (body_last) state_nx = READY;
            READY:   if (ld_go) state_nx = HDR;
                     else if (run_go) state_nx = RUN;
            RUN:     if (!run_go && rd_go && grp_last) state_nx = DONE;
            DONE:    if (ld_go) state_nx = HDR;
                     else if (run_go) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hdr_cnt     <= '0;
            tot         <= '0;
            wr_idx      <= '0;
            grp         <= '0;
            init_size   <= '0;
            input_size  <= '0;
            dff_size    <= '0;
            output_size <= '0;
            num_xor     <= '0;
            gate_size   <= '0;
            err         <= 1'b0;
            last        <= 1'b0;
        end else begin
            state <= state_nx;
            if (ld_go) begin
                hdr_cnt     <= '0;
                tot         <= '0;
                wr_idx      <= '0;
                init_size   <= '0;
                input_size  <= '0;
                dff_size    <= '0;
                output_size <= '0;
                num_xor     <= '0;
                gate_size   <= '0;
                err         <= 1'b0;
                last        <= 1'b0;
            end
            if (xfer && state == HDR) begin
                hdr_cnt <= hdr_cnt + 2'd1;
                case (hdr_cnt)
                    2'd0: init_size  <= load_data[2*S-1:S] + load_data[S-1:0];
                    2'd1: input_size <= load_data[2*S-1:S] + load_data[S-1:0];
                    2'd2: begin
                        dff_size    <= load_data[2*S-1:S];
                        output_size <= load_data[S-1:0];
                    end
                    default: begin
                        num_xor   <= load_data[2*S-1:S];
                        gate_size <= load_data[S-1:0];
                        tot       <= hdr_total;
                        if (overflow) err <= 1'b1;
                    end
                endcase
            end
            if (xfer && state == BODY) wr_idx <= wr_idx + 1'b1;
            if (run_go) begin
                grp  <= '0;
                last <= 1'b0;
            end else if (rd_go) begin
                grp  <= grp + 1'b1;
                last <= grp_last;
            end
            if (xor_bad) err <= 1'b1;
        end
    end

    // Body word k lands in bank k mod LANES; a read group g fetches row g of every bank.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic we, in_range;

        assign we       = xfer && (state == BODY) && ((32'(wr_idx) & 32'(LANES - 1)) == 32'(l));
        assign in_range = (32'(grp) * LANES + 32'(l)) < 32'(tot);

        netlist_store_lane #(.S(S), .ROWS(ROWS), .AW(AW)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .we         (we),
            .waddr      (wr_row),
            .wdata      (load_data),
            .re         (rd_go),
            .raddr      (grp[AW-1:0]),
            .in_range   (in_range),
            .clr        (ld_go || run_go),
            .lim        (lim),
            .gate_valid (gate_valid[l]),
            .is_output  (is_output[l]),
            .g_logic    (g_logic[4*l +: 4]),
            .in0        (in0[S*l +: S]),
            .in1        (in1[S*l +: S]),
            .in0F       (in0F[l]),
            .in1F       (in1F[l])
        );
    end
endmodule
